// File: rtl/q_loop_top_if.sv
// Bundle between the system controller / resonant stage and the Q regulator.
interface q_loop_top_if #(
  parameter int BUS_WIDTH = 10
);
  logic                 start;
  logic                 enable;
  logic                 q_serialized;
  logic [BUS_WIDTH-1:0] q_desired;
  logic [BUS_WIDTH-1:0] i_ref_out;
  logic [BUS_WIDTH-1:0] q_measured;
  logic                 ready;
  logic                 converged;

  // Controller/plant side: drives the commands and the pulse train
  modport master (
    output start, enable, q_serialized, q_desired,
    input  i_ref_out, q_measured, ready, converged
  );

  // Regulator side
  modport slave (
    input  start, enable, q_serialized, q_desired,
    output i_ref_out, q_measured, ready, converged
  );
endinterface

// File: rtl/q_loop_top.sv
// Closed-loop charge regulator: measures Q from a serial pulse train, steps the
// current reference toward q_desired and optionally backs off on a Q collapse.
module q_loop_top #(
  parameter int BUS_WIDTH         = 10,
  parameter int WTD_BUS_WIDTH     = 3,
  parameter int Q_PER_PULSE       = 3,
  parameter int TOL               = 6,
  parameter int I_REF_DELTA_INSTB = 10,
  parameter int DELTA_Q_INSTB     = 50,
  parameter int INCLUDE_Q_DROP    = 0
) (
  input  logic         clk,
  input  logic         rst,
  q_loop_top_if.slave  bus
);
  localparam int                     PROD_W   = 2 * BUS_WIDTH + 1;
  localparam logic [BUS_WIDTH-1:0]   Q_MAX    = '1;
  // Burst closes on the cycle the idle count would reach 2**W-1
  localparam logic [WTD_BUS_WIDTH-1:0] WDT_LAST = WTD_BUS_WIDTH'((2 ** WTD_BUS_WIDTH) - 2);
  localparam logic [BUS_WIDTH-1:0]   TOL_C    = BUS_WIDTH'(TOL);
  localparam logic [BUS_WIDTH-1:0]   BACKOFF  = BUS_WIDTH'(I_REF_DELTA_INSTB);
  localparam logic [BUS_WIDTH-1:0]   DELTA_C  = BUS_WIDTH'(DELTA_Q_INSTB);

  function automatic logic [BUS_WIDTH-1:0] sat_add(input logic [BUS_WIDTH-1:0] a,
                                                   input logic [BUS_WIDTH-1:0] b,
                                                   input logic [BUS_WIDTH-1:0] ceil);
    logic [BUS_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, ceil}) return ceil;
    return s[BUS_WIDTH-1:0];
  endfunction

  function automatic logic [BUS_WIDTH-1:0] sat_sub(input logic [BUS_WIDTH-1:0] a,
                                                   input logic [BUS_WIDTH-1:0] b);
    logic [BUS_WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[BUS_WIDTH]) return '0;
    return d[BUS_WIDTH-1:0];
  endfunction

  function automatic logic [BUS_WIDTH-1:0] sat_scale(input logic [BUS_WIDTH-1:0] cnt);
    logic [PROD_W-1:0] p;
    p = PROD_W'(cnt) * PROD_W'(Q_PER_PULSE);
    if (p > PROD_W'(Q_MAX)) return Q_MAX;
    return p[BUS_WIDTH-1:0];
  endfunction

  logic [2:0]               sync_q;
  logic                     edge_det;
  logic [BUS_WIDTH-1:0]     cnt_q, cnt_d;
  logic [WTD_BUS_WIDTH-1:0] wdt_q, wdt_d;
  logic                     seen_q, seen_d;
  logic [BUS_WIDTH-1:0]     qm_q, qm_d;
  logic                     rdy_q, rdy_d;
  logic [BUS_WIDTH-1:0]     iref_q, iref_d;
  logic                     conv_q, conv_d;
  logic [BUS_WIDTH-1:0]     ceil_q, ceil_d;
  logic                     ceil_set_q, ceil_set_d;
  logic [BUS_WIDTH-1:0]     prevq_q, prevq_d;
  logic                     prev_inc_q, prev_inc_d;

  logic [BUS_WIDTH-1:0]     err, step, ceiling;
  logic [BUS_WIDTH:0]       drop_w;
  logic                     within_tol, q_drop, instab;

  // Two-flop synchronizer plus a history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], bus.q_serialized};
  end

  assign edge_det = sync_q[1] & ~sync_q[2];

  // Pulse counting and idle watchdog; an edge always wins over expiry
  always_comb begin
    cnt_d  = cnt_q;
    wdt_d  = wdt_q;
    seen_d = seen_q;
    qm_d   = qm_q;
    rdy_d  = 1'b0;
    if (!bus.start) begin
      cnt_d  = '0;
      wdt_d  = '0;
      seen_d = 1'b0;
    end else if (edge_det) begin
      cnt_d  = (cnt_q == Q_MAX) ? cnt_q : cnt_q + 1'b1;
      wdt_d  = '0;
      seen_d = 1'b1;
    end else if (seen_q) begin
      if (wdt_q == WDT_LAST) begin
        qm_d   = sat_scale(cnt_q);
        rdy_d  = 1'b1;
        cnt_d  = '0;
        wdt_d  = '0;
        seen_d = 1'b0;
      end else begin
        wdt_d = wdt_q + 1'b1;
      end
    end
  end

  // Error magnitude, step size and the instability trigger
  assign err        = (qm_q > bus.q_desired) ? qm_q - bus.q_desired : bus.q_desired - qm_q;
  assign step       = ((err >> 2) == '0) ? BUS_WIDTH'(1) : (err >> 2);
  assign within_tol = (err <= TOL_C);
  assign ceiling    = ceil_set_q ? ceil_q : Q_MAX;
  assign drop_w     = {1'b0, prevq_q} - {1'b0, qm_q};
  assign q_drop     = !drop_w[BUS_WIDTH] && (drop_w[BUS_WIDTH-1:0] > DELTA_C);
  assign instab     = (INCLUDE_Q_DROP != 0) && prev_inc_q && q_drop;

  // Control update, evaluated once per measurement strobe
  always_comb begin
    iref_d     = iref_q;
    conv_d     = conv_q;
    ceil_d     = ceil_q;
    ceil_set_d = ceil_set_q;
    prevq_d    = prevq_q;
    prev_inc_d = prev_inc_q;
    if (rdy_q) begin
      prevq_d = qm_q;
      if (bus.enable) begin
        conv_d     = within_tol;
        prev_inc_d = 1'b0;
        if (instab) begin
          iref_d     = sat_sub(iref_q, BACKOFF);
          ceil_d     = iref_d;
          ceil_set_d = 1'b1;
        end else if (!within_tol) begin
          if (qm_q < bus.q_desired) begin
            iref_d     = sat_add(iref_q, step, ceiling);
            prev_inc_d = 1'b1;
          end else begin
            iref_d = sat_sub(iref_q, step);
          end
        end
      end
    end
  end

  // State registers; everything clears on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      wdt_q      <= '0;
      seen_q     <= 1'b0;
      qm_q       <= '0;
      rdy_q      <= 1'b0;
      iref_q     <= '0;
      conv_q     <= 1'b0;
      ceil_q     <= '0;
      ceil_set_q <= 1'b0;
      prevq_q    <= '0;
      prev_inc_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wdt_q      <= wdt_d;
      seen_q     <= seen_d;
      qm_q       <= qm_d;
      rdy_q      <= rdy_d;
      iref_q     <= iref_d;
      conv_q     <= conv_d;
      ceil_q     <= ceil_d;
      ceil_set_q <= ceil_set_d;
      prevq_q    <= prevq_d;
      prev_inc_q <= prev_inc_d;
    end
  end

  assign bus.i_ref_out  = iref_q;
  assign bus.q_measured = qm_q;
  assign bus.ready      = rdy_q;
  assign bus.converged  = conv_q;
endmodule

// File: tb/tb_q_loop_top.sv
// Directed bench for q_loop_top with a burst-level reference model.
module tb_q_loop_top;
  localparam int BW   = 10;
  localparam int QMAX = 1023;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  q_loop_top_if #(.BUS_WIDTH(BW)) bus ();

  q_loop_top #(
    .BUS_WIDTH(BW), .WTD_BUS_WIDTH(3), .Q_PER_PULSE(3), .TOL(6),
    .I_REF_DELTA_INSTB(10), .DELTA_Q_INSTB(50), .INCLUDE_Q_DROP(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected measurement results, one per completed burst
  typedef struct { int rcyc; int q; } burst_t;
  burst_t pend[$];

  // Reference state of the regulator
  int m_iref = 0, m_conv = 0, m_qm = 0, m_prev_q = 0, m_prev_inc = 0, m_ceil = QMAX;

  task automatic check(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_iref = 0; m_conv = 0; m_qm = 0; m_prev_q = 0; m_prev_inc = 0; m_ceil = QMAX;
  endtask

  // Regulator behaviour on one measurement, in plain integer arithmetic
  task automatic model_update(input int q, input int en, input int qd);
    int err, step;
    if (en != 0) begin
      err    = (q > qd) ? q - qd : qd - q;
      m_conv = (err <= 6) ? 1 : 0;
      if (m_prev_inc != 0 && (m_prev_q - q) > 50) begin
        m_iref     = (m_iref > 10) ? m_iref - 10 : 0;
        m_ceil     = m_iref;
        m_prev_inc = 0;
      end else if (err > 6) begin
        step = (err / 4 < 1) ? 1 : err / 4;
        if (q < qd) begin
          m_iref     = (m_iref + step > m_ceil) ? m_ceil : m_iref + step;
          m_prev_inc = 1;
        end else begin
          m_iref     = (m_iref < step) ? 0 : m_iref - step;
          m_prev_inc = 0;
        end
      end else begin
        m_prev_inc = 0;
      end
    end
    m_prev_q = q;
    m_qm     = q;
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    bit exp_rdy;
    if (rst) begin
      check("rst_i_ref", bus.i_ref_out, 0);
      check("rst_q_measured", bus.q_measured, 0);
      check("rst_ready", bus.ready, 0);
      check("rst_converged", bus.converged, 0);
      model_reset();
    end else begin
      exp_rdy = (pend.size() > 0) && (pend[0].rcyc == cyc);
      check("ready", bus.ready, exp_rdy);
      check("i_ref_out", bus.i_ref_out, m_iref);
      check("converged", bus.converged, m_conv);
      if (exp_rdy) begin
        check("q_measured", bus.q_measured, pend[0].q);
        model_update(pend[0].q, bus.enable, bus.q_desired);
        void'(pend.pop_front());
      end else begin
        check("q_hold", bus.q_measured, m_qm);
      end
    end
  end

  // n pulses, 3 cycles high / 3 low; ready is due 3+7 cycles after the last rise
  task automatic burst(input int n, input bit expect_result);
    int last;
    burst_t b;
    last = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.q_serialized = 1'b1;
      last = cyc;
      repeat (3) @(posedge clk);
      #1 bus.q_serialized = 1'b0;
      if (i == n - 1 && !expect_result) bus.start = 1'b0;
      repeat (2) @(posedge clk);
    end
    #1;
    if (expect_result) begin
      b.rcyc = last + 10;
      b.q    = (3 * n > QMAX) ? QMAX : 3 * n;
      pend.push_back(b);
    end
  endtask

  task automatic settle();
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.q_serialized = 1'b0;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic lit(input string nm, input int iref, input int conv);
    check({nm, "_i_ref"}, bus.i_ref_out, iref);
    check({nm, "_model_i_ref"}, m_iref, iref);
    check({nm, "_converged"}, bus.converged, conv);
  endtask

  initial begin
    int up_exp[5];
    int dn_exp[5];
    int t0;
    up_exp = '{255, 510, 765, 1020, 1023};
    dn_exp = '{768, 513, 258, 3, 0};

    bus.start = 1'b1;
    bus.enable = 1'b1;
    bus.q_serialized = 1'b0;
    bus.q_desired = 10'd45;
    @(posedge clk); #1;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    lit("idle", 0, 0);
    check("idle_q_measured", bus.q_measured, 0);

    // 10 pulses -> Q=30, err 15, step 3
    burst(10, 1'b1); settle();
    check("b10_q_measured", bus.q_measured, 30);
    lit("b10", 3, 0);

    // 14 pulses -> Q=42, within tolerance of 45
    burst(14, 1'b1); settle();
    lit("b14", 3, 1);

    // Target change while converged leaves converged set until next ready
    bus.q_desired = 10'd100;
    repeat (20) @(posedge clk); #1;
    lit("qd_change", 3, 1);

    // Q=30 vs 100: err 70, step 17
    burst(10, 1'b1); settle();
    lit("b10_up", 20, 0);

    // start dropped mid-burst discards the count and gives no ready
    burst(5, 1'b0);
    repeat (15) @(posedge clk); #1;
    bus.start = 1'b1;
    check("abort_q_measured", bus.q_measured, 30);

    // enable low freezes control while measurement continues
    bus.enable = 1'b0;
    burst(20, 1'b1); settle();
    check("frozen_q_measured", bus.q_measured, 60);
    lit("frozen", 20, 0);
    bus.enable = 1'b1;

    // Raise then collapse: 300 -> 240 after an increase
    bus.q_desired = 10'd1000;
    burst(100, 1'b1); settle();
    lit("raise", 195, 0);
    burst(80, 1'b1); settle();
    lit("instab", 185, 0);
    burst(10, 1'b1); settle();
    lit("ceil1", 185, 0);
    burst(10, 1'b1); settle();
    lit("ceil2", 185, 0);

    // Reset restores the full ceiling
    do_reset();
    repeat (3) @(posedge clk); #1;
    lit("rst2", 0, 0);
    bus.q_desired = 10'd1023;
    burst(400, 1'b1); settle();
    check("sat_q_measured", bus.q_measured, 1023);
    lit("sat_q", 0, 1);
    for (int i = 0; i < 5; i++) begin
      burst(1, 1'b1); settle();
      lit("inc_sat", up_exp[i], 0);
    end
    bus.q_desired = 10'd0;
    for (int i = 0; i < 5; i++) begin
      burst(400, 1'b1); settle();
      lit("dec_sat", dn_exp[i], 0);
    end

    // Closed loop with a plant emitting 1 + i_ref/2 pulses per burst
    for (int v = 0; v < 4; v++) begin
      bus.q_desired = 10'($urandom_range(180, 40));
      do_reset();
      t0 = cyc;
      while (!bus.converged && (cyc - t0) < 50000) begin
        burst(1 + int'(bus.i_ref_out) / 2, 1'b1);
        settle();
      end
      check("sweep_converged", bus.converged, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
